// File: rtl/multdiv_pkg.sv
// multdiv_pkg - shared types and constants for the iterative multiply/divide unit.
//   md_op_t    : operation encoding on the op port (MULT, DIV, MULTU, DIVU)
//   md_state_t : sequencer states (IDLE, RUN, FIX, DONE)
//   MD_ITER    : number of RUN iterations, one per operand bit
package multdiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_DIV   = 2'b01,
    MD_MULTU = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } md_state_t;

  localparam int MD_ITER = 32;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// div_step - one combinational restoring-division step.
//   rem      in  WIDTH  current partial remainder (always < divisor)
//   divisor  in  WIDTH  divisor magnitude
//   next_bit in  1      next dividend bit shifted into the remainder
//   new_rem  out WIDTH  partial remainder after this step
//   q_bit    out 1      quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             next_bit,
  output logic [WIDTH-1:0] new_rem,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // WIDTH+1-bit trial subtract. Because rem < divisor, trial < 2*divisor, so
  // the top bit of diff is exactly the borrow: clear means trial >= divisor.
  always_comb begin
    trial = {rem, next_bit};
    diff  = trial - {1'b0, divisor};
    if (diff[WIDTH] == 1'b0) begin
      q_bit   = 1'b1;
      new_rem = diff[WIDTH-1:0];
    end else begin
      q_bit   = 1'b0;
      new_rem = trial[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit - iterative multicycle multiply/divide unit owning HI/LO.
//   clk, reset  : clock; synchronous active-high reset
//   start       : one-cycle request, accepted only in IDLE
//   op          : 00 MULT, 01 DIV, 10 MULTU, 11 DIVU
//   a, b        : rs / rt operands
//   busy        : operation in flight (RUN or FIX)
//   done        : one-cycle completion pulse, HI/LO already updated
//   div_zero    : qualifies done; divide with b==0 (HI/LO untouched)
//   hiOut/loOut : HI and LO registers
// Optional feature macro: MULTDIV_UNSIGNED_EN enables MULTU/DIVU (op[1]);
// without it every operation is signed.
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut
);

  // Two's-complement negate of a WIDTH-bit value.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1'b1);
  endfunction

  md_state_t          state;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               sign_a;
  logic               sign_b;
  logic               is_div;
  // Upper half: running product sum / partial remainder.
  // Lower half: multiplier / dividend bits still to consume, replaced by
  // product low bits / quotient bits as iterations proceed.
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  md_op_t             op_dec;
  logic               in_div;
  logic               in_unsigned;
  logic               in_sign_a;
  logic               in_sign_b;
  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   div_rem;
  logic               div_q;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_quot;
  logic [WIDTH-1:0]   fix_rem;

  assign hiOut = hi;
  assign loOut = lo;

  // Operand decode: operation class, signs and magnitudes captured on start.
  always_comb begin
    op_dec = md_op_t'(op);
    in_div = (op_dec == MD_DIV) || (op_dec == MD_DIVU);
`ifdef MULTDIV_UNSIGNED_EN
    in_unsigned = (op_dec == MD_MULTU) || (op_dec == MD_DIVU);
`else
    in_unsigned = 1'b0;
`endif
    in_sign_a = a[WIDTH-1] & ~in_unsigned;
    in_sign_b = b[WIDTH-1] & ~in_unsigned;
    // |-2^(WIDTH-1)| wraps to itself, which is the correct unsigned magnitude.
    in_mag_a  = in_sign_a ? neg_w(a) : a;
    in_mag_b  = in_sign_b ? neg_w(b) : b;
  end

  // Shift-add multiply step: add multiplicand when the current multiplier
  // bit (acc[0]) is set, then shift the whole accumulator right by one.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc[2*WIDTH-1:WIDTH]),
    .divisor  (mag_b),
    .next_bit (acc[WIDTH-1]),
    .new_rem  (div_rem),
    .q_bit    (div_q)
  );

  // Restoring divide step: remainder replaces the upper half, the quotient
  // bit enters at the bottom as the dividend shifts left.
  always_comb begin
    div_next = {div_rem, acc[WIDTH-2:0], div_q};
  end

  // Sign fix-up applied to the magnitude result before it lands in HI/LO.
  always_comb begin
    fix_prod = (sign_a ^ sign_b) ? (~acc + (2*WIDTH)'(1'b1)) : acc;
    fix_quot = (sign_a ^ sign_b) ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    fix_rem  = sign_a ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
  end

  // Sequencer: IDLE -> RUN (WIDTH iterations) -> FIX -> DONE -> IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MD_IDLE;
      mag_a    <= '0;
      mag_b    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      is_div   <= 1'b0;
      acc      <= '0;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          if (start) begin
            if (in_div && (b == '0)) begin
              // Divide by zero: report immediately, HI/LO untouched.
              done     <= 1'b1;
              div_zero <= 1'b1;
              state    <= MD_DONE;
            end else begin
              mag_a  <= in_mag_a;
              mag_b  <= in_mag_b;
              sign_a <= in_sign_a;
              sign_b <= in_sign_b;
              is_div <= in_div;
              // Running sum/remainder cleared; low half seeded with the
              // operand whose bits are consumed one per iteration.
              acc    <= {{WIDTH{1'b0}}, (in_div ? in_mag_a : in_mag_b)};
              count  <= '0;
              busy   <= 1'b1;
              state  <= MD_RUN;
            end
          end
        end
        MD_RUN: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count + CNT_W'(1);
          if (count == CNT_W'(MD_ITER - 1)) begin
            state <= MD_FIX;
          end
        end
        MD_FIX: begin
          if (is_div) begin
            hi <= fix_rem;
            lo <= fix_quot;
          end else begin
            hi <= fix_prod[2*WIDTH-1:WIDTH];
            lo <= fix_prod[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= MD_DONE;
        end
        MD_DONE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          state    <= MD_IDLE;
        end
        default: begin
          busy     <= 1'b0;
          done     <= 1'b0;
          div_zero <= 1'b0;
          state    <= MD_IDLE;
        end
      endcase
    end
  end

endmodule
